spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- Sequences decoded 16-bit SPI frames from the SPI deserializer into the PWM configuration register bank.
- Validates each frame: write bit and address range.
- Commits valid frames one at a time, drops invalid ones, counts errors and exposes the five active configuration bytes to the PWM block.
- Sits between the SPI peripheral and the PWM generator.

Parameters:
- MAX_ADDR, 4: highest valid register address; addresses 0..MAX_ADDR are writable.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_valid  in  1  frame available from SPI deserializer
- frame_ready  out  1  controller can accept a frame
- frame_data  in  16  [15]=write bit (1=write), [14:8]=address, [7:0]=data
- period_end  in  1  single-cycle pulse at PWM period boundary
- err_clr  in  1  clears err_cnt
- en_reg_out_7_0  out  8  register 0
- en_reg_out_15_8  out  8  register 1
- en_reg_pwm_7_0  out  8  register 2
- en_reg_pwm_15_8  out  8  register 3
- pwm_duty_cycle  out  8  register 4
- wr_pulse  out  1  one-cycle strobe when a register is committed
- wr_addr  out  7  address of last committed write, valid with wr_pulse
- err_cnt  out  ERR_W  count of dropped frames, saturating
- busy  out  1  high whenever state != IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on posedge clk.
- Reset values:
  - all five register outputs 0x00
  - wr_pulse 0, wr_addr 0, err_cnt 0, busy 0
  - state IDLE, frame_ready 1 in the first cycle after reset deasserts
- FSM states: IDLE, DECODE, COMMIT, DROP.
- IDLE:
  - frame_ready=1.
  - On frame_valid&frame_ready at edge E0, latch frame_data; next state DECODE.
- DECODE (frame_ready=0):
  - If latched bit15=1 and address<=MAX_ADDR, go to COMMIT; else go to DROP.
- COMMIT:
  - At edge E2, write data to the addressed register.
  - wr_pulse=1 and wr_addr=address for exactly the cycle after E2.
  - Return to IDLE.
- DROP:
  - At edge E2, err_cnt increments, saturating at 2^ERR_W-1.
  - No register changes and no wr_pulse.
  - Return to IDLE.
- Latency: a committed value is visible on its output port after E2, i.e. 2 clocks after the accept edge.
- Throughput: one frame per 3 clocks.
- frame_valid held high continuously: the next frame is accepted at the first IDLE edge.
- frame_valid while not ready: the frame is not consumed. The producer holds frame_data stable until accepted.
- err_clr and a DROP increment on the same edge: clear wins, err_cnt=0.
- Address width is 7 bits and the compare is unsigned. Address 0x7F drops.
- Reset asserted in any state: return to IDLE next edge, discard the latched frame, restore all reset values. No partial write.

Optional Feature:
- Macro SPI_REG_SHADOW_EN.
- Defined:
  - COMMIT writes a shadow bank, and wr_pulse still fires.
  - On each period_end pulse, all five shadow bytes copy into the active outputs on the same edge.
  - If COMMIT and period_end coincide on one edge, the new byte lands in shadow only. Active outputs take the pre-write shadow contents, and the new byte appears at the following period_end.
  - Reset clears the shadow bank and the active outputs.
- Undefined:
  - Writes go directly to the active outputs.
  - period_end is ignored; the port remains present.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum spi_ctrl_state_t (IDLE, DECODE, COMMIT, DROP)
  - address localparams ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_DUTY=4
  - NUM_REGS=5
  - frame field bit positions
- One sub-module, spi_reg_bank:
  - NUM_REGS x 8 storage with write-enable and address inputs.
  - Holds the shadow/active copy logic under SPI_REG_SHADOW_EN.
  - The FSM, frame validation and error counter stay in spi_reg_ctrl.

Test Plan:
- Reset then frame 0x8480 (write, addr 4, data 0x80) → pwm_duty_cycle=0x80 two clocks after accept; wr_pulse for one cycle with wr_addr=4; err_cnt=0.
- Frames 0x80F0, 0x81CC, 0x8255, 0x83AA back-to-back with frame_valid held high → each accepted 3 clocks apart; registers 0..3 = F0, CC, 55, AA.
- Frame 0x0512 (write bit 0), then 0x8A33 (addr 10) → no register change, no wr_pulse, err_cnt=2.
- err_cnt at 255, another invalid frame → stays 255. err_clr on the same edge as a DROP → 0.
- rst asserted during DECODE of frame 0x8477 → pwm_duty_cycle stays 0x00, busy=0 and frame_ready=1 the cycle after rst deasserts.
- With SPI_REG_SHADOW_EN: write 0x8440, check pwm_duty_cycle stays 0x00 until period_end, then 0x40. Write 0x8411 committing on the same edge as period_end → stays 0x40 and becomes 0x11 at the next period_end.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller: FSM states, register
// map addresses and frame field positions.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        COMMIT = 2'd2,
        DROP   = 2'd3
    } spi_ctrl_state_t;

    localparam int unsigned ADDR_EN_OUT_LO = 0;
    localparam int unsigned ADDR_EN_OUT_HI = 1;
    localparam int unsigned ADDR_EN_PWM_LO = 2;
    localparam int unsigned ADDR_EN_PWM_HI = 3;
    localparam int unsigned ADDR_DUTY      = 4;
    localparam int unsigned NUM_REGS       = 5;

    // Frame layout: [15] write, [14:8] address, [7:0] data
    localparam int unsigned FRAME_WR_BIT   = 15;
    localparam int unsigned FRAME_ADDR_MSB = 14;
    localparam int unsigned FRAME_ADDR_LSB = 8;
    localparam int unsigned FRAME_DATA_MSB = 7;
    localparam int unsigned FRAME_DATA_LSB = 0;
    localparam int unsigned ADDR_W         = FRAME_ADDR_MSB - FRAME_ADDR_LSB + 1;

endpackage

// File: rtl/spi_reg_bank.sv
// Configuration register storage, NUM_REGS x 8 bits.
// With SPI_REG_SHADOW_EN defined, writes land in a shadow bank that is copied
// to the active outputs on each period_end pulse; otherwise writes go straight
// to the active outputs and period_end is ignored.
module spi_reg_bank
    import spi_reg_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we_i,
    input  logic [ADDR_W-1:0]            waddr_i,
    input  logic [7:0]                   wdata_i,
    input  logic                         period_end_i,
    output logic [NUM_REGS-1:0][7:0]     regs_o
);

    logic [NUM_REGS-1:0][7:0] active_q;

`ifdef SPI_REG_SHADOW_EN
    logic [NUM_REGS-1:0][7:0] shadow_q;

    // Shadow takes writes; active copies the pre-write shadow on period_end
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we_i && (waddr_i == ADDR_W'(i))) begin
                    shadow_q[i] <= wdata_i;
                end
            end
            if (period_end_i) begin
                active_q <= shadow_q;
            end
        end
    end
`else
    logic unused_period_end;
    assign unused_period_end = period_end_i;

    // Direct write into the active registers
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we_i && (waddr_i == ADDR_W'(i))) begin
                    active_q[i] <= wdata_i;
                end
            end
        end
    end
`endif

    assign regs_o = active_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Sequences SPI frames into the PWM configuration register bank: accepts one
// frame, validates write bit and address, then commits or drops it.
// Optional shadow banking is enabled by defining SPI_REG_SHADOW_EN.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned MAX_ADDR = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic [15:0]       frame_data,
    input  logic              period_end,
    input  logic              err_clr,
    output logic [7:0]        en_reg_out_7_0,
    output logic [7:0]        en_reg_out_15_8,
    output logic [7:0]        en_reg_pwm_7_0,
    output logic [7:0]        en_reg_pwm_15_8,
    output logic [7:0]        pwm_duty_cycle,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(MAX_ADDR);
    localparam logic [ERR_W-1:0]  ErrMax  = '1;

    spi_ctrl_state_t          state_q;
    logic [15:0]              frame_q;
    logic                     wr_pulse_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic [ERR_W-1:0]         err_cnt_q;
    logic [ADDR_W-1:0]        frame_addr;
    logic [7:0]               frame_wdata;
    logic                     frame_ok;
    logic [NUM_REGS-1:0][7:0] regs;

    assign frame_addr  = frame_q[FRAME_ADDR_MSB:FRAME_ADDR_LSB];
    assign frame_wdata = frame_q[FRAME_DATA_MSB:FRAME_DATA_LSB];
    assign frame_ok    = frame_q[FRAME_WR_BIT] && (frame_addr <= MaxAddr);

    // Frame sequencing FSM with registered strobe, address and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            wr_pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (frame_valid) begin
                        frame_q <= frame_data;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    state_q <= frame_ok ? COMMIT : DROP;
                end
                COMMIT: begin
                    wr_pulse_q <= 1'b1;
                    wr_addr_q  <= frame_addr;
                    state_q    <= IDLE;
                end
                DROP: begin
                    if (err_cnt_q != ErrMax) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Clear has priority over a same-edge increment
            if (err_clr) begin
                err_cnt_q <= '0;
            end
        end
    end

    spi_reg_bank u_bank (
        .clk          (clk),
        .rst          (rst),
        .we_i         (state_q == COMMIT),
        .waddr_i      (frame_addr),
        .wdata_i      (frame_wdata),
        .period_end_i (period_end),
        .regs_o       (regs)
    );

    assign frame_ready     = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign wr_pulse        = wr_pulse_q;
    assign wr_addr         = wr_addr_q;
    assign err_cnt         = err_cnt_q;
    assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs[ADDR_DUTY];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl.
module tb_spi_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [15:0] frame_data = '0;
    logic        period_end = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic        wr_pulse;
    logic [6:0]  wr_addr;
    logic [7:0]  err_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    spi_reg_ctrl #(
        .MAX_ADDR (4),
        .ERR_W    (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_valid     (frame_valid),
        .frame_ready     (frame_ready),
        .frame_data      (frame_data),
        .period_end      (period_end),
        .err_clr         (err_clr),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_pulse        (wr_pulse),
        .wr_addr         (wr_addr),
        .err_cnt         (err_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!frame_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", {31'b0, frame_ready}, 32'd1);
    endtask

    // Present one frame, then run to just after its commit/drop edge
    task automatic send(input logic [15:0] f);
        wait_ready();
        frame_valid = 1'b1;
        frame_data  = f;
        tick();
        frame_valid = 1'b0;
        tick();
        tick();
    endtask

    logic [15:0] b2b [4];
    int          acc [4];

    initial begin
        b2b[0] = 16'h80F0;
        b2b[1] = 16'h81CC;
        b2b[2] = 16'h8255;
        b2b[3] = 16'h83AA;

        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", {31'b0, frame_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_duty", {24'b0, pwm_duty_cycle}, 32'h00);
        check("rst_reg0", {24'b0, en_reg_out_7_0}, 32'h00);
        check("rst_err", {24'b0, err_cnt}, 32'd0);
        check("rst_wrp", {31'b0, wr_pulse}, 32'd0);
        check("rst_wra", {25'b0, wr_addr}, 32'd0);

        // Single write: visible two edges after accept
        frame_valid = 1'b1;
        frame_data  = 16'h8480;
        tick();
        frame_valid = 1'b0;
        check("w1_busy", {31'b0, busy}, 32'd1);
        check("w1_notready", {31'b0, frame_ready}, 32'd0);
        tick();
        check("w1_duty_early", {24'b0, pwm_duty_cycle}, 32'h00);
        check("w1_wrp_early", {31'b0, wr_pulse}, 32'd0);
        tick();
        check("w1_duty", {24'b0, pwm_duty_cycle}, 32'h80);
        check("w1_wrp", {31'b0, wr_pulse}, 32'd1);
        check("w1_wra", {25'b0, wr_addr}, 32'd4);
        tick();
        check("w1_wrp_off", {31'b0, wr_pulse}, 32'd0);
        check("w1_err", {24'b0, err_cnt}, 32'd0);

        // Back-to-back with frame_valid held high
        frame_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame_data = b2b[i];
            wait_ready();
            acc[i] = cyc;
            tick();
        end
        frame_valid = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 4; i++) begin
            check("b2b_spacing", acc[i] - acc[i-1], 32'd3);
        end
        check("b2b_reg0", {24'b0, en_reg_out_7_0}, 32'hF0);
        check("b2b_reg1", {24'b0, en_reg_out_15_8}, 32'hCC);
        check("b2b_reg2", {24'b0, en_reg_pwm_7_0}, 32'h55);
        check("b2b_reg3", {24'b0, en_reg_pwm_15_8}, 32'hAA);
        check("b2b_duty", {24'b0, pwm_duty_cycle}, 32'h80);

        // Invalid frames: read op and out-of-range address
        send(16'h0512);
        check("inv1_wrp", {31'b0, wr_pulse}, 32'd0);
        send(16'h8A33);
        check("inv2_wrp", {31'b0, wr_pulse}, 32'd0);
        check("inv_err", {24'b0, err_cnt}, 32'd2);
        check("inv_reg1", {24'b0, en_reg_out_15_8}, 32'hCC);
        check("inv_reg2", {24'b0, en_reg_pwm_7_0}, 32'h55);

        // Saturation
        for (int i = 0; i < 253; i++) begin
            send(16'h8512);
        end
        check("sat_255", {24'b0, err_cnt}, 32'd255);
        send(16'hFF01);
        check("sat_hold", {24'b0, err_cnt}, 32'd255);
        check("addr7f_duty", {24'b0, pwm_duty_cycle}, 32'h80);

        // err_clr on the same edge as a DROP increment
        wait_ready();
        frame_valid = 1'b1;
        frame_data  = 16'h0000;
        tick();
        frame_valid = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_wins", {24'b0, err_cnt}, 32'd0);
        send(16'h8501);
        check("addr5_drop", {24'b0, err_cnt}, 32'd1);

        // Reset during DECODE discards the frame
        wait_ready();
        frame_valid = 1'b1;
        frame_data  = 16'h8477;
        tick();
        frame_valid = 1'b0;
        check("rd_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rd_busy0", {31'b0, busy}, 32'd0);
        check("rd_ready", {31'b0, frame_ready}, 32'd1);
        check("rd_err", {24'b0, err_cnt}, 32'd0);
        tick();
        tick();
        check("rd_duty", {24'b0, pwm_duty_cycle}, 32'h00);
        check("rd_reg3", {24'b0, en_reg_pwm_15_8}, 32'h00);
        check("rd_wrp", {31'b0, wr_pulse}, 32'd0);

`ifdef SPI_REG_SHADOW_EN
        send(16'h8440);
        check("sh_wrp", {31'b0, wr_pulse}, 32'd1);
        check("sh_hold", {24'b0, pwm_duty_cycle}, 32'h00);
        tick();
        check("sh_hold2", {24'b0, pwm_duty_cycle}, 32'h00);
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("sh_copy", {24'b0, pwm_duty_cycle}, 32'h40);
        // Commit coincides with period_end
        wait_ready();
        frame_valid = 1'b1;
        frame_data  = 16'h8411;
        tick();
        frame_valid = 1'b0;
        tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("sh_coin", {24'b0, pwm_duty_cycle}, 32'h40);
        tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("sh_next", {24'b0, pwm_duty_cycle}, 32'h11);
`else
        send(16'h8440);
        check("dir_duty", {24'b0, pwm_duty_cycle}, 32'h40);
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("dir_pe_ignored", {24'b0, pwm_duty_cycle}, 32'h40);
        wait_ready();
        frame_valid = 1'b1;
        frame_data  = 16'h8411;
        tick();
        frame_valid = 1'b0;
        tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("dir_coin", {24'b0, pwm_duty_cycle}, 32'h11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
